// File: rtl/seq_mul_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_mul_add_pkg                                                 |
// | Purpose  : Shared definitions for the sequential arithmetic blocks         |
// |            (shift-add multiply-accumulate and restoring divider):          |
// |            controller state encoding and iteration-count width.            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package seq_mul_add_pkg;

   // The iteration counter is 8 bits, which covers operand widths up to 255.
   localparam int CNT_W = 8;

   // Controller state encoding. The value 2'b11 is unused and treated as illegal.
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

endpackage : seq_mul_add_pkg
`default_nettype wire

// File: rtl/seq_mul_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_mul_add                                                     |
// | Purpose  : Radix-2 shift-add multiply-accumulate, product = a*b + c.        |
// |            One multiplier bit is processed per clock. This block is the     |
// |            arithmetic inverse of the restoring divider: it rebuilds the     |
// |            dividend from quotient, divisor and remainder.                   |
// | Ports    : clk     - clock, rising edge                                    |
// |            rst     - asynchronous active-high reset                        |
// |            start   - request, sampled only in IDLE                         |
// |            a[N]    - multiplicand (captured on accept)                     |
// |            b[M]    - multiplier   (captured on accept)                     |
// |            c[M]    - addend       (captured on accept)                     |
// |            product - a*b+c, valid while done=1                             |
// |            done    - result valid                                          |
// |            busy    - high while computing                                  |
// |            cnt     - multiplier bits processed so far (0..M)               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_mul_add
   import seq_mul_add_pkg::*;
#(
   parameter int N = 64,
   parameter int M = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     a,
   input  logic [M-1:0]     b,
   input  logic [M-1:0]     c,
   output logic [N+M-1:0]   product,
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] cnt
);

   localparam int               W     = N + M;
   localparam logic [CNT_W-1:0] M_CNT = CNT_W'(M);

   logic [1:0]       state_q,  state_d;
   logic [W-1:0]     acc_q,    acc_d;
   logic [W-1:0]     mcand_q,  mcand_d;
   logic [M-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             done_q,   done_d;
   logic             busy_q,   busy_d;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)          state_d = S_CALC;
         S_CALC:  if (cnt_q == M_CNT) state_d = S_DONE;
         S_DONE:  if (!start)         state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // Next values of the datapath and the registered outputs.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      busy_d   = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = {{M{1'b0}}, a};
               mplier_d = b;
               acc_d    = {{N{1'b0}}, c};
               cnt_d    = '0;
               done_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         S_CALC: begin
            if (cnt_q < M_CNT) begin
               // Width N+M holds the largest a*b+c exactly, so the add never wraps.
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end else begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
         S_DONE: begin
            // product is left untouched so it stays readable until the next start.
            if (!start) done_d = 1'b0;
         end
         default: begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   assign product = acc_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign cnt     = cnt_q;

endmodule : seq_mul_add
`default_nettype wire
